// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA raster timing generator feeding the ppu and the VGA DAC.
//
// Free-running horizontal/vertical counters produce the pixel coordinate and
// decoded strobes for the ppu, which are all undelayed. The sync and blanking
// signals pass through a SYNC_DELAY-deep register chain. This delay lines them
// up with the ppu pixel pipeline.
//
// Ports:
//   clock        in   pixel clock
//   reset        in   synchronous, active-high
//   x, y         out  10-bit hcount / vcount, undelayed (0 while reset)
//   active       out  visible-region flag, undelayed
//   line_start   out  hcount == 0, undelayed
//   frame_start  out  hcount == 0 && vcount == 0, undelayed
//   hsync        out  active-low hsync, delayed SYNC_DELAY clocks
//   vsync        out  active-low vsync, delayed SYNC_DELAY clocks
//   blank_n      out  delayed copy of active (0 = blanking)
//   frame_count  out  8-bit frame counter (only with VGA_SYNC_FRAME_CNT_EN)
//
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN adds frame_count.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n
`ifdef VGA_SYNC_FRAME_CNT_EN
 ,output logic [7:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Idle pattern {hsync, vsync, blank_n} used for reset and the delay fill.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hWrap;
  logic       frameWrap;
  logic       hsyncRaw;
  logic       vsyncRaw;
  logic       activeRaw;

  assign hWrap     = (hCount == H_LAST);
  assign frameWrap = hWrap && (vCount == V_LAST);

  // Stage p0: raster counters
  always_ff @(posedge clock) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hWrap) begin
      hCount <= '0;
      vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
    end else begin
      hCount <= hCount + 10'd1;
    end
  end

  assign hsyncRaw  = !((hCount >= H_SYNC_START) && (hCount < H_SYNC_END));
  assign vsyncRaw  = !((vCount >= V_SYNC_START) && (vCount < V_SYNC_END));
  assign activeRaw = (hCount < H_VIS) && (vCount < V_VIS);

  // The counters only clear on the reset edge, so the undelayed outputs are
  // gated to read idle for the whole time reset is high.
  assign x           = reset ? 10'd0 : hCount;
  assign y           = reset ? 10'd0 : vCount;
  assign active      = activeRaw && !reset;
  assign line_start  = (hCount == 10'd0) && !reset;
  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0) && !reset;

  generate
    if (SYNC_DELAY == 0) begin : gNoDelay
      assign hsync   = hsyncRaw || reset;
      assign vsync   = vsyncRaw || reset;
      assign blank_n = active;
    end else begin : gDelay
      logic [2:0] syncPipe_p1 [SYNC_DELAY];

      // Stage p1..pN: sync/blank delay chain matching the ppu latency
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < int'(SYNC_DELAY); i++) syncPipe_p1[i] <= SYNC_IDLE;
        end else begin
          syncPipe_p1[0] <= {hsyncRaw, vsyncRaw, activeRaw};
          for (int i = 1; i < int'(SYNC_DELAY); i++) syncPipe_p1[i] <= syncPipe_p1[i-1];
        end
      end

      // Held idle during reset itself, not just after the reset edge.
      assign hsync   = syncPipe_p1[SYNC_DELAY-1][2] || reset;
      assign vsync   = syncPipe_p1[SYNC_DELAY-1][1] || reset;
      assign blank_n = syncPipe_p1[SYNC_DELAY-1][0] && !reset;
    end
  endgenerate

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)          frame_count <= '0;
    else if (frameWrap) frame_count <= frame_count + 8'd1;
  end
`else
  logic unusedFrameWrap;
  assign unusedFrameWrap = frameWrap;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen. A full-size instance checks
// reset, release and line-level timing. A reduced-timing instance, with no sync
// delay, checks the frame-level behaviour (vsync, wrap, frame_count).
module tb_vga_sync_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       active, line_start, frame_start, hsync, vsync, blank_n;

  logic       sReset;
  logic [9:0] sx, sy;
  logic       sActive, sLineStart, sFrameStart, sHsync, sVsync, sBlankN;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frameCount, sFrameCount;
`endif

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  vga_sync_gen dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .active(active),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n)
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,.frame_count(frameCount)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_DELAY(0)
  ) dutSmall (
    .clock(clock), .reset(sReset), .x(sx), .y(sy), .active(sActive),
    .line_start(sLineStart), .frame_start(sFrameStart),
    .hsync(sHsync), .vsync(sVsync), .blank_n(sBlankN)
`ifdef VGA_SYNC_FRAME_CNT_EN
   ,.frame_count(sFrameCount)
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int t640, t656, fall1, fall2, blankFall, lowLen, fsCount, vLow;
    int sHLow, sVLow, sAct, sFs;
    logic prevH, prevB, found;

    reset  = 1'b1;
    sReset = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    checkEq("rst_x", x, 0);
    checkEq("rst_y", y, 0);
    checkEq("rst_hsync", hsync, 1);
    checkEq("rst_vsync", vsync, 1);
    checkEq("rst_blank_n", blank_n, 0);
    checkEq("rst_frame_start", frame_start, 0);
    checkEq("rst_active", active, 0);
    checkEq("rst_line_start", line_start, 0);

    // Release: the current cycle is the first with counters at (0,0).
    reset = 1'b0;
    #1;
    checkEq("rel0_x", x, 0);
    checkEq("rel0_y", y, 0);
    checkEq("rel0_frame_start", frame_start, 1);
    checkEq("rel0_active", active, 1);
    checkEq("rel0_line_start", line_start, 1);
    checkEq("rel0_blank_n", blank_n, 0);
    checkEq("rel0_hsync", hsync, 1);
    @(negedge clock);
    checkEq("rel1_x", x, 1);
    checkEq("rel1_frame_start", frame_start, 0);
    checkEq("rel1_blank_n", blank_n, 0);
    @(negedge clock);
    checkEq("rel2_x", x, 2);
    checkEq("rel2_blank_n", blank_n, 1);
    checkEq("rel2_hsync", hsync, 1);

    // Line timing, cycles k = 2..1700 after release.
    t640 = -1; t656 = -1; fall1 = -1; fall2 = -1; blankFall = -1;
    lowLen = 0; fsCount = 0; vLow = 0;
    prevH = hsync; prevB = blank_n;
    for (int k = 3; k <= 1700; k++) begin
      @(negedge clock);
      if (x == 10'd640 && t640 < 0) t640 = k;
      if (x == 10'd656 && t656 < 0) t656 = k;
      if (prevH && !hsync) begin
        if (fall1 < 0) fall1 = k; else if (fall2 < 0) fall2 = k;
      end
      if (!hsync && fall2 < 0) lowLen++;
      if (prevB && !blank_n && blankFall < 0) blankFall = k;
      if (frame_start) fsCount++;
      if (!vsync) vLow++;
      if (k == 800) begin
        checkEq("line1_x", x, 0);
        checkEq("line1_y", y, 1);
        checkEq("line1_line_start", line_start, 1);
      end
      prevH = hsync; prevB = blank_n;
    end
    checkEq("x640_cycle", t640, 640);
    checkEq("hsync_fall_after_656", fall1 - t656, 2);
    checkEq("hsync_low_width", lowLen, 96);
    checkEq("hsync_period", fall2 - fall1, 800);
    checkEq("blank_fall_after_640", blankFall - t640, 2);
    checkEq("no_frame_start_midframe", fsCount, 0);
    checkEq("vsync_high_lines0_2", vLow, 0);

    // Reset mid-frame at (123, 2).
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (x == 10'd123 && y == 10'd2) found = 1'b1;
      else @(negedge clock);
    end
    checkEq("reach_123_2", found, 1);
    reset = 1'b1;
    #1;
    checkEq("midrst_x", x, 0);
    checkEq("midrst_blank_n", blank_n, 0);
    checkEq("midrst_hsync", hsync, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkEq("mid0_x", x, 0);
    checkEq("mid0_y", y, 0);
    checkEq("mid0_frame_start", frame_start, 1);
    checkEq("mid0_blank_n", blank_n, 0);
    checkEq("mid0_vsync", vsync, 1);
    @(negedge clock);
    checkEq("mid1_x", x, 1);
    checkEq("mid1_blank_n", blank_n, 0);
    checkEq("mid1_hsync", hsync, 1);
    @(negedge clock);
    checkEq("mid2_blank_n", blank_n, 1);
    checkEq("mid2_x", x, 2);

    // Reduced timing: H total 7, V total 5, frame 35 clocks, no sync delay.
    sReset = 1'b0;
    #1;
    checkEq("s_rel_frame_start", sFrameStart, 1);
    checkEq("s_rel_blank_n", sBlankN, 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    checkEq("s_fc_start", sFrameCount, 0);
`endif
    sHLow = 0; sVLow = 0; sAct = 0; sFs = 0;
    for (int k = 0; k < 35; k++) begin
      if (k > 0) @(negedge clock);
      if (!sHsync) sHLow++;
      if (!sVsync) sVLow++;
      if (sBlankN) sAct++;
      if (sFrameStart) sFs++;
      if (k == 34) begin
        checkEq("s_last_x", sx, 6);
        checkEq("s_last_y", sy, 4);
      end
    end
    checkEq("s_hsync_low_per_frame", sHLow, 5);
    checkEq("s_vsync_low_clks", sVLow, 7);
    checkEq("s_active_clks", sAct, 8);
    checkEq("s_frame_start_count", sFs, 1);
    @(negedge clock);
    checkEq("s_wrap_x", sx, 0);
    checkEq("s_wrap_y", sy, 0);
    checkEq("s_wrap_frame_start", sFrameStart, 1);
    checkEq("s_wrap_line_start", sLineStart, 1);
    checkEq("s_wrap_active", sActive, 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
    checkEq("s_fc_1", sFrameCount, 1);
    repeat (35 * 254) @(negedge clock);
    checkEq("s_fc_255", sFrameCount, 255);
    repeat (35) @(negedge clock);
    checkEq("s_fc_wrap0", sFrameCount, 0);
    checkEq("s_fc_wrap_x", sx, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
